// File: rtl/rv_pkg.sv
// Shared fetch/decode definitions: default datapath width, the canonical NOP,
// and the {pc, instr} entry layout carried between fetch and decode.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with show-ahead read, occupancy count and a
// single-cycle flush. Entry contents are never cleared; only pointers/count are.
module sync_fifo #(
  parameter int W = 64,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [W-1:0]       wdata,
  output logic [W-1:0]       rdata,
  output logic [$clog2(D):0] count,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(D);

  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [W-1:0]  mem_rd [D];

  // One register per entry; the read side is a plain mux so decode sees the
  // head in the same cycle it becomes valid.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_entry
      logic [W-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign mem_rd[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign rdata = mem_rd[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(D));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: buffers {PC, instr} pairs, stalls the PC
// when full, drops everything on redirect, and shows a NOP to decode when empty.
module fetch_queue #(
  parameter int          WIDTH     = rv_pkg::XLEN,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         PCF,
  input  logic [31:0]              InstrF,
  input  logic                     FetchValid,
  output logic                     stall,
  input  logic                     flush,
  input  logic                     DecodeReady,
  output logic                     DecodeValid,
  output logic [31:0]              InstrD,
  output logic [WIDTH-1:0]         PCD,
  output logic [WIDTH-1:0]         PCPlus4D,
  output logic [$clog2(DEPTH):0]   count
);

  import rv_pkg::*;

  localparam int EW = WIDTH + 32;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head_raw;

  // A fetch arriving while full is dropped; the PC is held by stall and will
  // present the same pair again.
  assign push = FetchValid && !full && !flush;
  assign pop  = !empty && DecodeReady && !flush;

  sync_fifo #(
    .W(EW),
    .D(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({PCF, InstrF}),
    .rdata (head_raw),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // stall follows registered occupancy, so a same-cycle pop frees the PC one cycle later.
  assign stall       = full;
  assign DecodeValid = !empty;

  // Stale entry contents never leak: outputs are forced to constants when empty.
  assign PCD      = empty ? '0 : head_raw[EW-1:32];
  assign InstrD   = empty ? NOP_INSTR : head_raw[31:0];
  assign PCPlus4D = PCD + WIDTH'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed bench for fetch_queue: a queue-based model of the FIFO
// contents feeds a scoreboard that a negedge monitor checks against the DUT.
module tb_fetch_queue;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        FetchValid;
  logic        stall;
  logic        flush;
  logic        DecodeReady;
  logic        DecodeValid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [2:0]  count;

  int           tests = 0;
  int           fails = 0;
  int           mcount = 0;
  bit           armed = 1'b0;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .InstrF      (InstrF),
    .FetchValid  (FetchValid),
    .stall       (stall),
    .flush       (flush),
    .DecodeReady (DecodeReady),
    .DecodeValid (DecodeValid),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .count       (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: state after the last edge vs model; inputs seen here are the ones
  // about to be applied, so a handshake retires the scoreboard head.
  fetch_entry_t head;
  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() == 0) begin
        head.pc    = 32'h0;
        head.instr = 32'h00000013;
      end else begin
        head = exp_q[0];
      end
      chk("count",       32'(count),       32'(mcount));
      chk("DecodeValid", 32'(DecodeValid), 32'(mcount > 0));
      chk("stall",       32'(stall),       32'(mcount == DEPTH));
      chk("PCD",         PCD,              head.pc);
      chk("InstrD",      InstrD,           head.instr);
      chk("PCPlus4D",    PCPlus4D,         head.pc + 32'd4);
      if (DecodeValid && DecodeReady && !flush && !rst && exp_q.size() > 0) begin
        $display("[TB] decode pc=%h instr=%h", PCD, InstrD);
        void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, then advance the model at the edge.
  task automatic cyc(input bit r, input bit fv, input logic [31:0] pc, input logic [31:0] ins,
                     input bit fl, input bit dr);
    bit push_ok;
    bit pop_ok;
    rst         = r;
    FetchValid  = fv;
    PCF         = pc;
    InstrF      = ins;
    flush       = fl;
    DecodeReady = dr;
    push_ok = fv && !r && !fl && (mcount < DEPTH);
    pop_ok  = dr && !r && !fl && (mcount > 0);
    @(posedge clk);
    if (r || fl) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      if (push_ok) exp_q.push_back('{pc: pc, instr: ins});
      mcount = mcount + int'(push_ok) - int'(pop_ok);
    end
    #1;
    armed = 1'b1;
  endtask

  initial begin
    // Reset with fetch active.
    cyc(1, 1, 32'h40, 32'hDEAD, 0, 0);
    cyc(1, 1, 32'h44, 32'hBEEF, 0, 1);
    chk("rst_count",   32'(count),       32'd0);
    chk("rst_dv",      32'(DecodeValid), 32'd0);
    chk("rst_stall",   32'(stall),       32'd0);
    chk("rst_instr",   InstrD,           32'h00000013);
    chk("rst_pcd",     PCD,              32'h0);
    chk("rst_pcplus4", PCPlus4D,         32'h4);

    // Fill without decode, then an extra fetch that must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 32'(i * 4), 32'hA0 + 32'(i), 0, 0);
      $display("[TB] fill push pc=%h count=%0d stall=%0b", 32'(i * 4), count, stall);
    end
    chk("fill_stall", 32'(stall), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    cyc(0, 1, 32'h10, 32'hA4, 0, 0);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_pcd",   PCD,        32'h0);
    chk("drop_instr", InstrD,     32'hA0);
    chk("drop_pc4",   PCPlus4D,   32'h4);

    // Full with pop and push together: only the pop happens.
    cyc(0, 1, 32'h10, 32'hA4, 0, 1);
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_stall", 32'(stall), 32'd0);
    cyc(0, 1, 32'h10, 32'hA4, 0, 0);
    chk("repush_count", 32'(count), 32'd4);
    cyc(0, 0, 32'h0, 32'h0, 0, 1);
    chk("pre_flush_count", 32'(count), 32'd3);

    // Flush suppresses the concurrent push and pop.
    cyc(0, 1, 32'h100, 32'hB0, 1, 1);
    chk("flush_count", 32'(count),       32'd0);
    chk("flush_dv",    32'(DecodeValid), 32'd0);
    cyc(0, 1, 32'h100, 32'hB0, 0, 0);
    chk("postflush_pcd", PCD, 32'h100);

    // Streaming across pointer wrap, ending at the top of the address space.
    for (int i = 0; i <= 2 * DEPTH; i++) begin
      logic [31:0] pc;
      pc = (i == 2 * DEPTH) ? 32'hFFFFFFFC : 32'(i * 4);
      cyc(0, 1, pc, 32'hC0 + 32'(i), 0, 1);
      chk("stream_count", 32'(count),       32'd1);
      chk("stream_dv",    32'(DecodeValid), 32'd1);
    end
    chk("wrap_pcd", PCD,      32'hFFFFFFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 0, 1);
    chk("drain_count", 32'(count), 32'd0);

    // Random traffic including occasional redirects and resets.
    for (int i = 0; i < 500; i++) begin
      bit r, fv, fl, dr;
      r  = ($urandom_range(0, 99) < 2);
      fv = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 5);
      dr = ($urandom_range(0, 99) < 55);
      cyc(r, fv, $urandom & 32'hFFFFFFFC, $urandom, fl, dr);
    end
    cyc(0, 0, 32'h0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
